clk_div_cfg: RTL and testbench

//  Configuration front-end for the divided-clock generators.
//  - Accepts a new 16-bit divisor over a valid/ready handshake.
//  - Classifies it as bypass, odd or even.
//  - Applies it to the divider's i_divisor input only at a safe point: the synced

---
 rtl/clk_div_pkg.sv | 25 ++
 rtl/clk_edge_sync.sv | 31 +++
 rtl/clk_div_cfg.sv | 166 ++++++++++++++++
 tb/tb_clk_div_cfg.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and divisor classification for the divided-clock configuration front-end.
package clk_div_pkg;

  localparam int DIV_W_DEF  = 16;
  // Divisors at or below this value mean "no division": downstream passes i_clk through.
  localparam int BYPASS_MAX = 1;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_EDGE = 2'd1;
  localparam logic [1:0] ST_APPLY     = 2'd2;
  localparam logic [1:0] ST_SETTLE    = 2'd3;

  typedef struct packed {
    logic bypass;
    logic odd_sel;
  } div_class_t;

  function automatic div_class_t classify(input logic [31:0] d);
    div_class_t c;
    c.bypass  = (d <= 32'(BYPASS_MAX));
    c.odd_sel = d[0] & ~c.bypass;
    return c;
  endfunction

endpackage

// File: rtl/clk_edge_sync.sv
// Synchronises the fed-back divided clock into i_clk and flags its edges.
// Edge flags are valid SYNC_STAGES cycles after the input moves; consumers register them.
module clk_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_sync = sync_q[SYNC_STAGES-1];
  assign o_rise = o_sync & ~hist_q;
  assign o_fall = ~o_sync & hist_q;

endmodule

// File: rtl/clk_div_cfg.sv
// Accepts a new divisor, applies it to the divider only on a synced divided-clock fall
// (or timeout), then reports lock after SETTLE_EDGES divided-clock rises.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int DIV_W        = DIV_W_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int SETTLE_EDGES = 4,
  parameter int TIMEOUT      = 4096
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_valid,
  input  logic [DIV_W-1:0] i_cfg_divisor,
  output logic             o_cfg_ready,
  input  logic             i_div_clk,
  output logic [DIV_W-1:0] o_divisor,
  output logic             o_odd_sel,
  output logic             o_bypass,
  output logic             o_locked,
  output logic             o_fault
);

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  SETTLE_N = 8'(SETTLE_EDGES);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] shadow_q, shadow_d;
  logic [DIV_W-1:0] divisor_q, divisor_d;
  logic             odd_q, odd_d;
  logic             bypass_q, bypass_d;
  logic             locked_q, locked_d;
  logic             fault_q, fault_d;
  logic             ready_q, ready_d;
  logic [15:0]      tmo_q, tmo_d;
  logic [7:0]       rise_cnt_q, rise_cnt_d;

  logic             sync_unused;
  logic             div_rise;
  logic             div_fall;
  div_class_t       shadow_cls;
  logic [15:0]      tmo_inc;
  logic [7:0]       rise_inc;
  logic             tmo_hit;

  clk_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_div_clk),
    .o_sync  (sync_unused),
    .o_rise  (div_rise),
    .o_fall  (div_fall)
  );

  assign shadow_cls = classify(32'(shadow_q));
  // Both counters saturate so a stuck condition can never wrap back into a valid count.
  assign tmo_inc    = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
  assign rise_inc   = (rise_cnt_q == 8'hFF) ? rise_cnt_q : rise_cnt_q + 8'd1;
  assign tmo_hit    = (tmo_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    divisor_d  = divisor_q;
    odd_d      = odd_q;
    bypass_d   = bypass_q;
    locked_d   = locked_q;
    fault_d    = fault_q;
    tmo_d      = tmo_q;
    rise_cnt_d = rise_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (i_cfg_valid) begin
          fault_d = 1'b0;
          if (i_cfg_divisor != divisor_q) begin
            shadow_d = i_cfg_divisor;
            locked_d = 1'b0;
            tmo_d    = 16'd0;
            // In bypass there is no divided clock to wait on.
            state_d  = bypass_q ? ST_APPLY : ST_WAIT_EDGE;
          end
        end
      end

      ST_WAIT_EDGE: begin
        tmo_d = tmo_inc;
        if (div_fall) begin
          state_d = ST_APPLY;
        end else if (tmo_hit) begin
          state_d = ST_APPLY;
          fault_d = 1'b1;
        end
      end

      ST_APPLY: begin
        divisor_d  = shadow_q;
        odd_d      = shadow_cls.odd_sel;
        bypass_d   = shadow_cls.bypass;
        tmo_d      = 16'd0;
        rise_cnt_d = 8'd0;
        state_d    = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (bypass_q) begin
          locked_d = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          tmo_d = tmo_inc;
          if (div_rise) begin
            rise_cnt_d = rise_inc;
          end
          if (div_rise && (rise_inc == SETTLE_N)) begin
            locked_d = 1'b1;
            state_d  = ST_IDLE;
          end else if (tmo_hit) begin
            fault_d  = 1'b1;
            locked_d = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      divisor_q  <= '0;
      odd_q      <= 1'b0;
      bypass_q   <= 1'b1;
      locked_q   <= 1'b1;
      fault_q    <= 1'b0;
      ready_q    <= 1'b1;
      tmo_q      <= 16'd0;
      rise_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      divisor_q  <= divisor_d;
      odd_q      <= odd_d;
      bypass_q   <= bypass_d;
      locked_q   <= locked_d;
      fault_q    <= fault_d;
      ready_q    <= ready_d;
      tmo_q      <= tmo_d;
      rise_cnt_q <= rise_cnt_d;
    end
  end

  assign o_cfg_ready = ready_q;
  assign o_divisor   = divisor_q;
  assign o_odd_sel   = odd_q;
  assign o_bypass    = bypass_q;
  assign o_locked    = locked_q;
  assign o_fault     = fault_q;

endmodule

// File: tb/tb_clk_div_cfg.sv
// Bench for clk_div_cfg: behavioural divider model drives the feedback clock, a scoreboard
// checks the settled outputs of every accepted request.
module tb_clk_div_cfg;

  localparam int SYNC   = 2;
  localparam int SETTLE = 4;
  // Large enough that a divisor of 9 locks (4 rises, ~40 cycles) without timing out.
  localparam int TMO    = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_vld = 1'b0;
  logic [15:0] cfg_div = 16'd0;
  logic        div_clk = 1'b0;
  logic        cfg_rdy;
  logic [15:0] divisor;
  logic        odd_sel, bypass, locked, fault;

  always #5 clk = ~clk;

  clk_div_cfg #(
    .DIV_W        (16),
    .SYNC_STAGES  (SYNC),
    .SETTLE_EDGES (SETTLE),
    .TIMEOUT      (TMO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_cfg_valid   (cfg_vld),
    .i_cfg_divisor (cfg_div),
    .o_cfg_ready   (cfg_rdy),
    .i_div_clk     (div_clk),
    .o_divisor     (divisor),
    .o_odd_sel     (odd_sel),
    .o_bypass      (bypass),
    .o_locked      (locked),
    .o_fault       (fault)
  );

  typedef struct packed {
    logic [15:0] div;
    logic        odd;
    logic        byp;
    logic        flt;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          fall_at[int];
  logic        prev_dclk = 1'b0;
  logic        stuck = 1'b0;
  int          dcnt = 0;
  logic [15:0] last_div = 16'd0;
  logic [15:0] m_div = 16'd0;
  bit          m_odd = 1'b0;
  bit          m_byp = 1'b1;
  bit          fire_next = 1'b0;
  bit          rst_next = 1'b0;
  bit          pending = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Divider model: period of o_divisor i_clk cycles, held low in bypass or when stuck.
  always @(negedge clk) begin
    if (stuck || bypass || divisor < 16'd2) begin
      dcnt    = 0;
      div_clk = 1'b0;
    end else begin
      if (divisor != last_div)               dcnt = 0;
      else if (dcnt + 1 >= int'(divisor))    dcnt = 0;
      else                                   dcnt++;
      div_clk = (dcnt < int'(divisor) / 2);
    end
    last_div = divisor;
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (prev_dclk && !div_clk) fall_at[cyc] = 1'b1;
    prev_dclk = div_clk;
  end

  // Monitor: a request is complete once the DUT is back to ready with lock asserted.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_next) pending = 1'b0;
    if (fire_next) pending = 1'b1;
    if (pending && cfg_rdy && locked) begin
      pending = 1'b0;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_completion: divisor=%0d with empty scoreboard", divisor);
      end else begin
        e = exp_q.pop_front();
        chk("done_divisor", divisor, e.div);
        chk("done_odd_sel", odd_sel, e.odd);
        chk("done_bypass",  bypass,  e.byp);
        chk("done_fault",   fault,   e.flt);
      end
    end
    fire_next = cfg_vld && cfg_rdy && rst_n;
    rst_next  = rst_n;
  end

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || pending) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: outstanding=%0d required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic model_accept(input logic [15:0] d, input bit stall, output bit chg);
    chg = (d != m_div);
    if (chg) begin
      m_div = d;
      m_byp = (d < 16'd2);
      m_odd = d[0] && !m_byp;
    end
    exp_q.push_back('{m_div, m_odd, m_byp, chg && stall});
  endtask

  task automatic issue(input logic [15:0] d, input bit stall);
    logic [15:0] old;
    bit          from_byp, chg;
    int          n;
    if (stall) begin
      stuck = 1'b1;
      repeat (8) @(posedge clk);
    end
    @(posedge clk); #1;
    cfg_vld = 1'b1;
    cfg_div = d;
    n = 0;
    while (!cfg_rdy && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    old      = m_div;
    from_byp = m_byp;
    model_accept(d, stall, chg);
    @(posedge clk); #1;
    cfg_vld = 1'b0;
    chk("fault_clear_on_accept", fault, 0);
    chk("ready_after_accept", cfg_rdy, !chg);
    chk("locked_after_accept", locked, !chg);
    if (chg) begin
      n = 0;
      while (divisor == old && n < 1000) begin
        @(posedge clk); #1;
        n++;
      end
      if (from_byp)   chk("apply_latency_from_bypass", n, 1);
      else if (stall) chk("apply_latency_timeout", n, TMO + 1);
      else            chk("apply_after_synced_fall", fall_at.exists(cyc - (SYNC + 1)), 1);
      if (m_byp) begin
        @(posedge clk); #1;
        chk("bypass_locked_next_cycle", locked, 1);
      end
    end
    drain();
    stuck = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    bit          chg;
    int          n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_divisor", divisor, 0);
    chk("rst_bypass",  bypass,  1);
    chk("rst_odd_sel", odd_sel, 0);
    chk("rst_locked",  locked,  1);
    chk("rst_ready",   cfg_rdy, 1);
    chk("rst_fault",   fault,   0);
    rst_n = 1'b1;

    issue(16'd5, 1'b0);
    issue(16'd8, 1'b0);
    issue(16'd1, 1'b0);
    issue(16'd1, 1'b0);
    issue(16'd5, 1'b0);
    issue(16'd6, 1'b1);
    issue(16'd7, 1'b0);
    issue(16'd7, 1'b0);

    for (int i = 0; i < 24; i++) begin
      d = 16'($urandom_range(0, 9));
      issue(d, 1'b0);
    end

    // Reset during SETTLE with a second request held on the interface.
    issue(16'd5, 1'b0);
    @(posedge clk); #1;
    cfg_vld = 1'b1;
    cfg_div = 16'd6;
    model_accept(16'd6, 1'b0, chg);
    @(posedge clk); #1;
    cfg_div = 16'd9;
    n = 0;
    while (divisor != 16'd6 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_settle", divisor, 6);
    for (int i = 0; i < 3; i++) begin
      chk("held_req_not_accepted", cfg_rdy, 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("midrst_divisor", divisor, 0);
    chk("midrst_bypass",  bypass,  1);
    chk("midrst_locked",  locked,  1);
    chk("midrst_ready",   cfg_rdy, 1);
    m_div = 16'd0;
    m_byp = 1'b1;
    m_odd = 1'b0;
    rst_n = 1'b1;
    model_accept(16'd9, 1'b0, chg);
    @(posedge clk); #1;
    cfg_vld = 1'b0;
    chk("held_req_taken_after_rst", cfg_rdy, 0);
    drain();
    issue(16'd9, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
